// File: rtl/stream_demux4_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  localparam int LANES         = 4;
  localparam int SEL_W         = 2;
  localparam int CNT_W_DEFAULT = 16;

  // Same {s1,s0} encoding as the 4:1 select mux.
  typedef enum logic [SEL_W-1:0] {
    LANE_A = 2'b00,
    LANE_B = 2'b01,
    LANE_C = 2'b10,
    LANE_D = 2'b11
  } lane_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux4_if.sv
// Input stream (word + lane select) and four output lanes of the demultiplexer.
interface stream_demux4_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_s0;
  logic               in_s1;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;

  // master: word source and lane consumers; slave: the demultiplexer.
  modport master (
    output in_valid, in_data, in_s0, in_s1, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_s0, in_s1, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux4_lane_slot.sv
// One-entry valid/ready lane slot with EMPTY/FULL state.
// STREAM_DEMUX4_LANE_CNT_EN adds a saturating output-handshake counter.
module demux_lane_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef STREAM_DEMUX4_LANE_CNT_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef STREAM_DEMUX4_LANE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      SLOT_EMPTY: if (load)           state_next = SLOT_FULL;
      SLOT_FULL:  if (ready && !load) state_next = SLOT_EMPTY;
      default:                        state_next = SLOT_EMPTY;
    endcase
  end

  assign valid = (state == SLOT_FULL);

  // NOTE: the data register is reset because out_data must read zero in reset;
  // a pure storage array with no such observable requirement would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data <= '0;
    else if (load) data <= din;
  end

`ifdef STREAM_DEMUX4_LANE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (valid && ready && ~&cnt)    cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/stream_demux4.sv
// Registered 1-to-4 stream demultiplexer: select decode, in_ready mux, lane packing.
// STREAM_DEMUX4_LANE_CNT_EN adds the lane_cnt output (per-lane handshake counters).
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef STREAM_DEMUX4_LANE_CNT_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stream_demux4_if.slave          bus
`ifdef STREAM_DEMUX4_LANE_CNT_EN
  ,
  output logic [LANES*CNT_W-1:0]  lane_cnt
`endif
);

  lane_e      sel;
  logic       accept;
  logic [3:0] load;

  assign sel = lane_e'({bus.in_s1, bus.in_s0});

  // Depends only on select and lane state, never on in_valid.
  assign bus.in_ready = !bus.out_valid[sel] || bus.out_ready[sel];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign load[i] = accept && (sel == lane_e'(i));

    demux_lane_slot #(
      .WIDTH (WIDTH)
`ifdef STREAM_DEMUX4_LANE_CNT_EN
      ,
      .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .din   (bus.in_data),
      .ready (bus.out_ready[i]),
      .valid (bus.out_valid[i]),
      .data  (bus.out_data[i*WIDTH +: WIDTH])
`ifdef STREAM_DEMUX4_LANE_CNT_EN
      ,
      .cnt   (lane_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4; counter steps run when STREAM_DEMUX4_LANE_CNT_EN is defined.
module tb_stream_demux4;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  stream_demux4_if #(.WIDTH(WIDTH)) bus ();

`ifdef STREAM_DEMUX4_LANE_CNT_EN
  logic [4*CNT_W-1:0] lane_cnt;
`endif

  stream_demux4 #(
    .WIDTH (WIDTH)
`ifdef STREAM_DEMUX4_LANE_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef STREAM_DEMUX4_LANE_CNT_EN
    ,
    .lane_cnt (lane_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] s, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_s1    = s[1];
    bus.in_s0    = s[0];
    bus.in_data  = d;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_s0     = 1'b0;
    bus.in_s1     = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;

    // Reset state
    #3;
    check("rst_out_valid", bus.out_valid, 4'b0000);
    check("rst_out_data", bus.out_data, 32'h0000_0000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: single word to lane C
    offer(2'b10, 8'hA5);
    tick();
    bus.in_valid = 1'b0;
    check("t1_out_valid", bus.out_valid, 4'b0100);
    check("t1_out_data", bus.out_data, 32'h00A5_0000);
    bus.out_ready = 4'b0100;
    tick();
    bus.out_ready = 4'b0000;
    check("t1_drained", bus.out_valid, 4'b0000);
    check("t1_data_held", bus.out_data, 32'h00A5_0000);

    // 2: backpressure on lane A, then lane B still accepts
    offer(2'b00, 8'h11);
    tick();
    offer(2'b00, 8'h22);
    #1;
    check("t2_in_ready_stall", bus.in_ready, 1'b0);
    tick();
    check("t2_a_kept_valid", bus.out_valid, 4'b0001);
    check("t2_a_kept_data", bus.out_data, 32'h00A5_0011);
    offer(2'b01, 8'h33);
    #1;
    check("t2_in_ready_b", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("t2_out_valid", bus.out_valid, 4'b0011);
    check("t2_out_data", bus.out_data, 32'h00A5_3311);
    bus.out_ready = 4'b0011;
    tick();
    bus.out_ready = 4'b0000;
    check("t2_drained", bus.out_valid, 4'b0000);

    // 3: pass-through refill on lane D
    offer(2'b11, 8'h01);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("t3_in_ready_full", bus.in_ready, 1'b0);
    bus.out_ready = 4'b1000;
    offer(2'b11, 8'h02);
    #1;
    check("t3_in_ready_refill", bus.in_ready, 1'b1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    check("t3_out_valid", bus.out_valid, 4'b1000);
    check("t3_out_data", bus.out_data, 32'h02A5_3311);
    bus.out_ready = 4'b1000;
    tick();
    bus.out_ready = 4'b0000;
    check("t3_drained", bus.out_valid, 4'b0000);

    // 4: parallel drain of all four lanes
    for (int i = 0; i < 4; i++) begin
      offer(i[1:0], 8'hA0 + 8'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    check("t4_all_full", bus.out_valid, 4'b1111);
    check("t4_all_data", bus.out_data, 32'hA3A2_A1A0);
    bus.out_ready = 4'b1111;
    tick();
    bus.out_ready = 4'b0000;
    check("t4_all_drained", bus.out_valid, 4'b0000);

    // 5: asynchronous reset between edges, then resume
    offer(2'b01, 8'h5B);
    tick();
    offer(2'b10, 8'h5C);
    tick();
    bus.in_valid = 1'b0;
    check("t5_pre_valid", bus.out_valid, 4'b0110);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", bus.out_valid, 4'b0000);
    check("t5_async_data", bus.out_data, 32'h0000_0000);
    #1;
    rst_n = 1'b1;
    tick();
    offer(2'b00, 8'h77);
    tick();
    bus.in_valid = 1'b0;
    check("t5_resume_valid", bus.out_valid, 4'b0001);
    check("t5_resume_data", bus.out_data, 32'h0000_0077);

`ifdef STREAM_DEMUX4_LANE_CNT_EN
    // 6: lane counters count output handshakes and saturate
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_cnt_rst", lane_cnt, 16'h0000);
    rst_n = 1'b1;
    tick();
    offer(2'b00, 8'h40);
    tick();
    bus.out_ready = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'h41 + 8'(i);
      tick();
      if (i == 2) check("t6_cnt_3", lane_cnt, 16'h0003);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    check("t6_cnt_sat", lane_cnt, 16'h000F);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_cnt_clear", lane_cnt, 16'h0000);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
